// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, status register layout and encodings for the writeback stage
//
// Holds the word/half-word widths, register index width, status register
// bit positions, the status-op encoding and the writeback FSM state type.
package cpu_pkg;

  localparam int WORD_W    = 20;
  localparam int HALF_W    = 10;
  localparam int REG_IDX_W = 4;
  localparam int NREGS     = 16;

  // Status register bit positions: {M, S, Z, C}
  localparam int SR_M = 3;
  localparam int SR_S = 2;
  localparam int SR_Z = 1;
  localparam int SR_C = 0;

  typedef enum logic [1:0] {
    SR_OP_FLAGS = 2'b00,
    SR_OP_LOAD  = 2'b01,
    SR_OP_XOR   = 2'b10,
    SR_OP_RSVD  = 2'b11
  } sr_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    WR_B = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_1w2r.sv
// rtl/regfile_1w2r.sv - register file with one synchronous write port and two asynchronous read ports
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low clear of every entry
//   we, waddr, wdata   write port, committed on the rising edge
//   raddr_a, raddr_b   read addresses
//   rdata_a, rdata_b   combinational read data (no write bypass)
module regfile_1w2r #(
  parameter int WORD_W = 20,
  parameter int NREGS  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [WORD_W-1:0] rdata_a,
  output logic [WORD_W-1:0] rdata_b
);

  logic [WORD_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents; a same-cycle write shows up next cycle.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback stage: register file commit, status register and retire pulse
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        transaction handshake (ready only in IDLE)
//   in_mode                    1 = full word, 0 = half word (upper bits cleared)
//   in_wr_a/in_dst_a/in_res_a  result A, written at the accept edge
//   in_wr_b/in_dst_b/in_res_b  result B, written one cycle later (swap)
//   in_flag_we, in_flags       per-flag update enables and values {S, Z, C}
//   in_sr_op                   00 flags, 01 load SR, 10 XOR SR, 11 as 00
//   rd_addr_*/rd_data_*        combinational register file reads
//   sr                         status register {M, S, Z, C}
//   wb_done                    one-cycle pulse when a transaction retires
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int WORD_W = cpu_pkg::WORD_W,
  parameter int HALF_W = cpu_pkg::HALF_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic                 in_wr_a,
  input  logic                 in_wr_b,
  input  logic [REG_IDX_W-1:0] in_dst_a,
  input  logic [REG_IDX_W-1:0] in_dst_b,
  input  logic [WORD_W-1:0]    in_res_a,
  input  logic [WORD_W-1:0]    in_res_b,
  input  logic [2:0]           in_flag_we,
  input  logic [2:0]           in_flags,
  input  logic [1:0]           in_sr_op,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [WORD_W-1:0]    rd_data_a,
  output logic [WORD_W-1:0]    rd_data_b,
  output logic [3:0]           sr,
  output logic                 wb_done
);

  state_t                 state;
  logic                   accept;
  logic                   b_mode;
  logic [REG_IDX_W-1:0]   b_dst;
  logic [WORD_W-1:0]      b_res;
  logic                   rf_we;
  logic [REG_IDX_W-1:0]   rf_waddr;
  logic [WORD_W-1:0]      rf_wdata;
  logic [3:0]             sr_next;

  function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] value,
                                                  input logic mode);
    logic [WORD_W-1:0] m;
    m = value;
    if (!mode) begin
      m[WORD_W-1:HALF_W] = '0;
    end
    return m;
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Single write port: the pending B write in WR_B owns it; A only writes in IDLE.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = in_dst_a;
    rf_wdata = mask_word(in_res_a, in_mode);
    if (state == WR_B) begin
      rf_we    = 1'b1;
      rf_waddr = b_dst;
      rf_wdata = mask_word(b_res, b_mode);
    end else if (accept && in_wr_a) begin
      rf_we    = 1'b1;
    end
  end

  // Load/XOR take the whole SR from res_a and ignore the flag enables;
  // the flags path never touches M.
  always_comb begin
    sr_next = sr;
    case (sr_op_t'(in_sr_op))
      SR_OP_LOAD: sr_next = in_res_a[3:0];
      SR_OP_XOR:  sr_next = sr ^ in_res_a[3:0];
      default: begin
        if (in_flag_we[2]) sr_next[SR_S] = in_flags[2];
        if (in_flag_we[1]) sr_next[SR_Z] = in_flags[1];
        if (in_flag_we[0]) sr_next[SR_C] = in_flags[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= 4'b0000;
      wb_done <= 1'b0;
      b_mode  <= 1'b0;
      b_dst   <= '0;
      b_res   <= '0;
    end else begin
      // Retire after the last write: immediately for single/no-write, after WR_B for a swap.
      wb_done <= (accept && !in_wr_b) || (state == WR_B);
      case (state)
        IDLE: begin
          if (accept) begin
            sr <= sr_next;
            if (in_wr_b) begin
              b_mode <= in_mode;
              b_dst  <= in_dst_b;
              b_res  <= in_res_b;
              state  <= WR_B;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  regfile_1w2r #(
    .WORD_W (WORD_W),
    .NREGS  (NREGS),
    .IDX_W  (REG_IDX_W)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rd_data_a),
    .rdata_b (rd_data_b)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for alu_writeback with a transaction-level reference model
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_mode, in_wr_a, in_wr_b;
  logic [3:0]  in_dst_a, in_dst_b, rd_addr_a, rd_addr_b, sr;
  logic [19:0] in_res_a, in_res_b, rd_data_a, rd_data_b;
  logic [2:0]  in_flag_we, in_flags;
  logic [1:0]  in_sr_op;
  logic        wb_done;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [19:0] m_rf [16];
  logic [3:0]  m_sr = 4'b0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [3:0]  m_b_dst;
  logic [19:0] m_b_val;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_wr_a    (in_wr_a),
    .in_wr_b    (in_wr_b),
    .in_dst_a   (in_dst_a),
    .in_dst_b   (in_dst_b),
    .in_res_a   (in_res_a),
    .in_res_b   (in_res_b),
    .in_flag_we (in_flag_we),
    .in_flags   (in_flags),
    .in_sr_op   (in_sr_op),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .sr         (sr),
    .wb_done    (wb_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: A and SR commit at acceptance, B one cycle later,
  // retirement is visible the cycle after the last commit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 20'h0;
      m_sr   = 4'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_busy) begin
      m_rf[m_b_dst] = m_b_val;
      m_busy = 1'b0;
      m_done = 1'b1;
    end else if (in_valid) begin
      if (in_wr_a) m_rf[in_dst_a] = in_mode ? in_res_a : in_res_a % 1024;
      if (in_sr_op == 2'd1)      m_sr = in_res_a % 16;
      else if (in_sr_op == 2'd2) m_sr = m_sr ^ (in_res_a % 16);
      else begin
        for (int i = 0; i < 3; i++)
          if (in_flag_we[i]) m_sr[i] = in_flags[i];
      end
      if (in_wr_b) begin
        m_busy  = 1'b1;
        m_b_dst = in_dst_b;
        m_b_val = in_mode ? in_res_b : in_res_b % 1024;
        m_done  = 1'b0;
      end else begin
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp_ready", in_ready, !m_busy);
      chk("cmp_done", wb_done, m_done);
      chk("cmp_sr", sr, m_sr);
      chk("cmp_rd_a", rd_data_a, m_rf[rd_addr_a]);
      chk("cmp_rd_b", rd_data_b, m_rf[rd_addr_b]);
    end
  end

  task automatic next_phase();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic mode, input logic wa, input logic wb,
                        input logic [3:0] da, input logic [3:0] db,
                        input logic [19:0] ra, input logic [19:0] rb,
                        input logic [2:0] fwe, input logic [2:0] fl,
                        input logic [1:0] op);
    in_mode = mode; in_wr_a = wa; in_wr_b = wb;
    in_dst_a = da; in_dst_b = db; in_res_a = ra; in_res_b = rb;
    in_flag_we = fwe; in_flags = fl; in_sr_op = op;
  endtask

  task automatic send(input logic mode, input logic wa, input logic wb,
                      input logic [3:0] da, input logic [3:0] db,
                      input logic [19:0] ra, input logic [19:0] rb,
                      input logic [2:0] fwe, input logic [2:0] fl,
                      input logic [1:0] op);
    set_in(mode, wa, wb, da, db, ra, rb, fwe, fl, op);
    in_valid = 1'b1;
    next_phase();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_addr_a = 0; rd_addr_b = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_sr", sr, 4'b0000);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_done", wb_done, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = i[3:0];
      #1;
      chk("rst_rf", rd_data_a, 20'h0);
    end
    next_phase();
    rst_n = 1'b1;
    check_en = 1'b1;
    next_phase();

    // Half-word masking
    send(0, 1, 0, 4'd3, 4'd0, 20'hFFFFF, 20'h0, 3'b000, 3'b000, 2'd0);
    rd_addr_a = 4'd3; #1;
    chk("half_mask", rd_data_a, 20'h003FF);
    chk("half_done", wb_done, 1'b1);

    // Full-word write
    send(1, 1, 0, 4'd3, 4'd0, 20'hFFFFF, 20'h0, 3'b000, 3'b000, 2'd0);
    rd_addr_a = 4'd3; #1;
    chk("full_word", rd_data_a, 20'hFFFFF);

    // Swap with a competing offer held during the stall cycle
    set_in(1, 1, 1, 4'd1, 4'd2, 20'h12345, 20'hABCDE, 3'b000, 3'b000, 2'd0);
    in_valid = 1'b1;
    next_phase();
    set_in(1, 1, 0, 4'd5, 4'd0, 20'h77777, 20'h0, 3'b111, 3'b111, 2'd1);
    rd_addr_a = 4'd1; rd_addr_b = 4'd2; #1;
    chk("swap_stall_ready", in_ready, 1'b0);
    chk("swap_a_plus1", rd_data_a, 20'h12345);
    chk("swap_b_plus1", rd_data_b, 20'h00000);
    chk("swap_done_plus1", wb_done, 1'b0);
    next_phase();
    in_valid = 1'b0;
    rd_addr_a = 4'd2; rd_addr_b = 4'd5; #1;
    chk("swap_b_plus2", rd_data_a, 20'hABCDE);
    chk("stall_not_taken", rd_data_b, 20'h00000);
    chk("swap_done_plus2", wb_done, 1'b1);
    chk("swap_ready_back", in_ready, 1'b1);
    chk("stall_sr_kept", sr, 4'b0000);
    next_phase();
    chk("swap_done_once", wb_done, 1'b0);

    // Status register paths
    send(0, 0, 0, 4'd0, 4'd0, 20'h0, 20'h0, 3'b010, 3'b111, 2'd0);
    chk("sr_flags", sr, 4'b0010);
    chk("nowrite_done", wb_done, 1'b1);
    send(0, 0, 0, 4'd0, 4'd0, 20'h00009, 20'h0, 3'b111, 3'b000, 2'd1);
    chk("sr_load", sr, 4'b1001);
    send(0, 0, 0, 4'd0, 4'd0, 20'h0000F, 20'h0, 3'b000, 3'b000, 2'd2);
    chk("sr_xor", sr, 4'b0110);
    send(0, 0, 0, 4'd0, 4'd0, 20'h00000, 20'h0, 3'b111, 3'b111, 2'd1);
    chk("sr_load_ignores_flags", sr, 4'b0000);
    send(0, 0, 0, 4'd0, 4'd0, 20'h0000E, 20'h0, 3'b001, 3'b001, 2'd3);
    chk("sr_reserved_as_flags", sr, 4'b0001);

    // Same destination: B written second wins
    send(0, 1, 1, 4'd4, 4'd4, 20'h11111, 20'h22222, 3'b000, 3'b000, 2'd0);
    rd_addr_a = 4'd4; #1;
    chk("same_dst_a_first", rd_data_a, 20'h00111);
    next_phase();
    chk("same_dst_b_wins", rd_data_a, 20'h00222);

    // Reset while B is pending
    send(1, 1, 1, 4'd6, 4'd7, 20'h55555, 20'h66666, 3'b000, 3'b000, 2'd0);
    rd_addr_a = 4'd6; rd_addr_b = 4'd7; #1;
    chk("rst_wrb_a_written", rd_data_a, 20'h55555);
    rst_n = 1'b0;
    #1;
    chk("rst_wrb_a_cleared", rd_data_a, 20'h00000);
    chk("rst_wrb_ready", in_ready, 1'b1);
    chk("rst_wrb_done", wb_done, 1'b0);
    next_phase();
    rst_n = 1'b1;
    next_phase();
    chk("rst_wrb_b_dropped", rd_data_b, 20'h00000);
    chk("rst_wrb_no_done", wb_done, 1'b0);
    chk("rst_wrb_idle", in_ready, 1'b1);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 600; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_mode    = $urandom_range(0, 1);
      in_wr_a    = $urandom_range(0, 1);
      in_wr_b    = ($urandom_range(0, 3) == 0);
      in_dst_a   = $urandom_range(0, 15);
      in_dst_b   = $urandom_range(0, 15);
      in_res_a   = $urandom_range(0, 20'hFFFFF);
      in_res_b   = $urandom_range(0, 20'hFFFFF);
      in_flag_we = $urandom_range(0, 7);
      in_flags   = $urandom_range(0, 7);
      in_sr_op   = $urandom_range(0, 3);
      rd_addr_a  = $urandom_range(0, 15);
      rd_addr_b  = $urandom_range(0, 15);
      next_phase();
    end
    in_valid = 1'b0;
    repeat (3) next_phase();
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
